// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1-style TAP controller: 16-state TMS decoder, 4-bit IR, BSR/ID/bypass data registers.
// Optional macro JTAG_IDCODE_EN adds the IDCODE instruction and 32-bit ID register (reset IR 4'h2 vs 4'hF).
module jtag_tap_ctrl #(
    parameter logic [31:0] IDCODE_VALUE = 32'h1000_0001,
    parameter int          BSR_W        = 8
) (
    input  logic             TCK,
    input  logic             rst,
    input  logic             TMS,
    input  logic             TDI,
    input  logic [BSR_W-1:0] CORE_LOGIC_BSR,
    input  logic             CORE_LOGIC_TDO,
    output logic             TDO,
    output logic             SHIFTDR,
    output logic             CAPTUREDR,
    output logic             UPDATEDR,
    output logic             SHIFTIR,
    output logic [3:0]       IR,
    output logic [BSR_W-1:0] BSR_UPDATE
);

    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAUSE_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PAUSE_IR, EX2_IR, UPD_IR
    } tap_state_e;

    typedef enum logic [1:0] {SEL_BSR, SEL_ID, SEL_CORE, SEL_BYP} dr_sel_e;

`ifdef JTAG_IDCODE_EN
    localparam logic [3:0] IR_DEFAULT = 4'h2;
`else
    localparam logic [3:0] IR_DEFAULT = 4'hF;
`endif

    tap_state_e       state_q, state_d;
    dr_sel_e          sel;
    logic [3:0]       ir_q, ir_sr_q;
    logic [BSR_W-1:0] bsr_sr_q, bsr_upd_q;
    logic             byp_q;
`ifdef JTAG_IDCODE_EN
    logic [31:0]      id_q;
`else
    logic             unused_idcode;
    assign unused_idcode = ^IDCODE_VALUE;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            TLR:      state_d = TMS ? TLR      : RTI;
            RTI:      state_d = TMS ? SEL_DR   : RTI;
            SEL_DR:   state_d = TMS ? SEL_IR   : CAP_DR;
            CAP_DR:   state_d = TMS ? EX1_DR   : SH_DR;
            SH_DR:    state_d = TMS ? EX1_DR   : SH_DR;
            EX1_DR:   state_d = TMS ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: state_d = TMS ? EX2_DR   : PAUSE_DR;
            EX2_DR:   state_d = TMS ? UPD_DR   : SH_DR;
            UPD_DR:   state_d = TMS ? SEL_DR   : RTI;
            SEL_IR:   state_d = TMS ? TLR      : CAP_IR;
            CAP_IR:   state_d = TMS ? EX1_IR   : SH_IR;
            SH_IR:    state_d = TMS ? EX1_IR   : SH_IR;
            EX1_IR:   state_d = TMS ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: state_d = TMS ? EX2_IR   : PAUSE_IR;
            EX2_IR:   state_d = TMS ? UPD_IR   : SH_IR;
            UPD_IR:   state_d = TMS ? SEL_DR   : RTI;
            default:  state_d = TLR;
        endcase
    end

    // Unlisted opcodes fall through to bypass so an unknown IR never breaks the chain.
    always_comb begin
        sel = SEL_BYP;
        case (ir_q)
            4'h0, 4'h1: sel = SEL_BSR;
`ifdef JTAG_IDCODE_EN
            4'h2:       sel = SEL_ID;
`endif
            4'h3:       sel = SEL_CORE;
            default:    sel = SEL_BYP;
        endcase
    end

    always_ff @(posedge TCK) begin
        if (rst) begin
            state_q   <= TLR;
            ir_q      <= IR_DEFAULT;
            ir_sr_q   <= '0;
            bsr_sr_q  <= '0;
            bsr_upd_q <= '0;
            byp_q     <= 1'b0;
`ifdef JTAG_IDCODE_EN
            id_q      <= '0;
`endif
        end else begin
            state_q <= state_d;
            case (state_q)
                TLR:    ir_q    <= IR_DEFAULT;
                CAP_IR: ir_sr_q <= 4'b0101;
                SH_IR:  ir_sr_q <= {TDI, ir_sr_q[3:1]};
                UPD_IR: ir_q    <= ir_sr_q;
                CAP_DR: begin
                    bsr_sr_q <= CORE_LOGIC_BSR;
                    byp_q    <= 1'b0;
`ifdef JTAG_IDCODE_EN
                    id_q     <= IDCODE_VALUE;
`endif
                end
                SH_DR: begin
                    case (sel)
                        SEL_BSR: bsr_sr_q <= {TDI, bsr_sr_q[BSR_W-1:1]};
`ifdef JTAG_IDCODE_EN
                        SEL_ID:  id_q     <= {TDI, id_q[31:1]};
`endif
                        SEL_BYP: byp_q    <= TDI;
                        default: ;
                    endcase
                end
                UPD_DR: if (sel == SEL_BSR) bsr_upd_q <= bsr_sr_q;
                default: ;
            endcase
        end
    end

    always_comb begin
        TDO = 1'b0;
        if (state_q == SH_IR) begin
            TDO = ir_sr_q[0];
        end else if (state_q == SH_DR) begin
            case (sel)
                SEL_BSR:  TDO = bsr_sr_q[0];
`ifdef JTAG_IDCODE_EN
                SEL_ID:   TDO = id_q[0];
`endif
                SEL_CORE: TDO = CORE_LOGIC_TDO;
                default:  TDO = byp_q;
            endcase
        end
    end

    assign SHIFTDR    = (state_q == SH_DR);
    assign CAPTUREDR  = (state_q == CAP_DR);
    assign UPDATEDR   = (state_q == UPD_DR);
    assign SHIFTIR    = (state_q == SH_IR);
    assign IR         = ir_q;
    assign BSR_UPDATE = bsr_upd_q;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Self-checking bench for jtag_tap_ctrl: scan-level reference model predicts TDO streams, IR and BSR_UPDATE.
module tb_jtag_tap_ctrl;

    localparam int          BSR_W  = 8;
    localparam logic [31:0] IDCODE = 32'h1000_0001;
`ifdef JTAG_IDCODE_EN
    localparam logic [3:0]  DEF_IR = 4'h2;
`else
    localparam logic [3:0]  DEF_IR = 4'hF;
`endif

    logic             TCK = 1'b0;
    logic             rst = 1'b1;
    logic             TMS = 1'b1;
    logic             TDI = 1'b0;
    logic [BSR_W-1:0] CORE_LOGIC_BSR = '0;
    logic             CORE_LOGIC_TDO = 1'b0;
    logic             TDO, SHIFTDR, CAPTUREDR, UPDATEDR, SHIFTIR;
    logic [3:0]       IR;
    logic [BSR_W-1:0] BSR_UPDATE;

    int vectors = 0;
    int errors  = 0;
    logic [3:0]       m_ir  = DEF_IR;
    logic [BSR_W-1:0] m_upd = '0;

    jtag_tap_ctrl #(.IDCODE_VALUE(IDCODE), .BSR_W(BSR_W)) dut (
        .TCK(TCK), .rst(rst), .TMS(TMS), .TDI(TDI),
        .CORE_LOGIC_BSR(CORE_LOGIC_BSR), .CORE_LOGIC_TDO(CORE_LOGIC_TDO),
        .TDO(TDO), .SHIFTDR(SHIFTDR), .CAPTUREDR(CAPTUREDR), .UPDATEDR(UPDATEDR),
        .SHIFTIR(SHIFTIR), .IR(IR), .BSR_UPDATE(BSR_UPDATE)
    );

    always #5 TCK = ~TCK;

    // Width of the data register an opcode selects; 0 marks the pass-through CORE path.
    function automatic int dr_width(input logic [3:0] op);
        case (op)
            4'h0, 4'h1: return BSR_W;
`ifdef JTAG_IDCODE_EN
            4'h2:       return 32;
`endif
            4'h3:       return 0;
            default:    return 1;
        endcase
    endfunction

    function automatic logic [63:0] dr_capture(input logic [3:0] op, input logic [BSR_W-1:0] bsr);
        case (op)
            4'h0, 4'h1: return {{(64-BSR_W){1'b0}}, bsr};
`ifdef JTAG_IDCODE_EN
            4'h2:       return {32'h0, IDCODE};
`endif
            default:    return 64'h0;
        endcase
    endfunction

    task automatic cyc(input logic tms, input logic tdi);
        TMS = tms;
        TDI = tdi;
        @(posedge TCK);
        #2;
    endtask

    // Starts and ends in Run-Test/Idle.
    task automatic scan_ir(input logic [3:0] op);
        logic [3:0] cap = 4'b0101;
        cyc(1, 0); cyc(1, 0); cyc(0, 0); cyc(0, 0);
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (SHIFTIR !== 1'b1 || TDO !== cap[i]) begin
                errors++;
                $display("FAIL ir_shift bit %0d: got SHIFTIR=%b TDO=%b, want 1/%b", i, SHIFTIR, TDO, cap[i]);
            end
            cyc(i == 3, op[i]);
        end
        cyc(1, 0);
        vectors++;
        if (IR !== m_ir) begin
            errors++;
            $display("FAIL ir_hold_at_upd: got %h want %h", IR, m_ir);
        end
        cyc(0, 0);
        m_ir = op;
        vectors++;
        if (IR !== m_ir) begin
            errors++;
            $display("FAIL ir_after_upd: got %h want %h", IR, m_ir);
        end
    endtask

    // Starts and ends in Run-Test/Idle; n shift cycles, optional pause after the shift.
    task automatic scan_dr(input int n, input bit pause, input logic [BSR_W-1:0] bsr);
        logic [63:0]      tdi_bits = {$urandom, $urandom};
        int               w        = dr_width(m_ir);
        logic [63:0]      cap      = dr_capture(m_ir, bsr);
        logic [BSR_W-1:0] r        = bsr;
        logic             exp;
        CORE_LOGIC_BSR = bsr;
        cyc(1, 0); cyc(0, 0);
        vectors++;
        if (CAPTUREDR !== 1'b1 || SHIFTDR !== 1'b0) begin
            errors++;
            $display("FAIL capdr_decode: got CAPTUREDR=%b SHIFTDR=%b want 1/0", CAPTUREDR, SHIFTDR);
        end
        cyc(0, 0);
        CORE_LOGIC_BSR = BSR_W'($urandom);
        for (int i = 0; i < n; i++) begin
            if (w == 0) CORE_LOGIC_TDO = 1'($urandom);
            #1;
            exp = (w == 0) ? CORE_LOGIC_TDO : (i < w) ? cap[i] : tdi_bits[i-w];
            vectors++;
            if (TDO !== exp || SHIFTDR !== 1'b1) begin
                errors++;
                $display("FAIL dr_shift ir=%h bit %0d: got TDO=%b SHIFTDR=%b want %b/1", m_ir, i, TDO, SHIFTDR, exp);
            end
            r = (r >> 1) | (BSR_W'(tdi_bits[i]) << (BSR_W-1));
            cyc(i == n-1, tdi_bits[i]);
        end
        vectors++;
        if (TDO !== 1'b0 || SHIFTDR !== 1'b0) begin
            errors++;
            $display("FAIL ex1dr: got TDO=%b SHIFTDR=%b want 0/0", TDO, SHIFTDR);
        end
        if (pause) begin
            cyc(0, 1);
            vectors++;
            if (TDO !== 1'b0) begin
                errors++;
                $display("FAIL pausedr_tdo: got %b want 0", TDO);
            end
            cyc(1, 0);
        end
        cyc(1, 0);
        vectors++;
        if (UPDATEDR !== 1'b1 || BSR_UPDATE !== m_upd) begin
            errors++;
            $display("FAIL upddr: got UPDATEDR=%b BSR_UPDATE=%h want 1/%h", UPDATEDR, BSR_UPDATE, m_upd);
        end
        cyc(0, 0);
        if (w == BSR_W && m_ir <= 4'h1) m_upd = r;
        vectors++;
        if (BSR_UPDATE !== m_upd) begin
            errors++;
            $display("FAIL bsr_update ir=%h: got %h want %h", m_ir, BSR_UPDATE, m_upd);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 12; i++) cyc(1'($urandom), 1'($urandom));
        rst = 1'b1;
        cyc(1'($urandom), 0);
        rst = 1'b0;
        m_ir  = DEF_IR;
        m_upd = '0;
        vectors++;
        if ({TDO, SHIFTDR, CAPTUREDR, UPDATEDR, SHIFTIR} !== 5'b0 || IR !== DEF_IR || BSR_UPDATE !== '0) begin
            errors++;
            $display("FAIL reset: got outs=%b IR=%h BSR_UPDATE=%h want 00000/%h/00",
                     {TDO, SHIFTDR, CAPTUREDR, UPDATEDR, SHIFTIR}, IR, BSR_UPDATE, DEF_IR);
        end
        cyc(0, 0);
    endtask

    task automatic test_tlr();
        for (int t = 0; t < 4; t++) begin
            scan_ir(4'h3);
            for (int i = 0; i < 9; i++) cyc(1'($urandom), 1'($urandom));
            for (int i = 0; i < 6; i++) cyc(1, 0);
            vectors++;
            if (IR !== DEF_IR || {TDO, SHIFTDR, CAPTUREDR, UPDATEDR, SHIFTIR} !== 5'b0) begin
                errors++;
                $display("FAIL tlr_return trial %0d: got IR=%h outs=%b want %h/00000", t, IR,
                         {TDO, SHIFTDR, CAPTUREDR, UPDATEDR, SHIFTIR}, DEF_IR);
            end
            m_ir = DEF_IR;
            rst = 1'b1;
            cyc(1, 0);
            rst = 1'b0;
            m_upd = '0;
            cyc(0, 0);
        end
    endtask

    task automatic test_idcode();
        scan_dr(32, 0, 8'h00);
        scan_dr(36, 1, 8'h00);
    endtask

    task automatic test_bypass();
        scan_ir(4'hF);
        scan_dr(9, 0, 8'h00);
        scan_ir(4'($urandom_range(4, 14)));
        scan_dr(int'($urandom_range(2, 20)), 1, 8'h00);
    endtask

    task automatic test_sample();
        scan_ir(4'h1);
        scan_dr(8, 0, 8'hDD);
        scan_dr(8, 1, 8'h5A);
        scan_ir(4'h0);
        scan_dr(13, 0, BSR_W'($urandom));
        scan_ir(4'hF);
        scan_dr(5, 0, BSR_W'($urandom));
    endtask

    task automatic test_random();
        logic [3:0] ops [6] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'hF, 4'h9};
        for (int k = 0; k < 20; k++) begin
            logic [3:0] op = ops[$urandom_range(0, 5)];
            if (op == 4'h9) op = 4'($urandom);
            scan_ir(op);
            scan_dr(int'($urandom_range(1, 40)), 1'($urandom), BSR_W'($urandom));
        end
    endtask

    task automatic test_core_reset();
        scan_ir(4'h3);
        cyc(1, 0); cyc(0, 0); cyc(0, 0);
        for (int i = 0; i < 6; i++) begin
            CORE_LOGIC_TDO = 1'($urandom);
            #1;
            vectors++;
            if (TDO !== CORE_LOGIC_TDO || SHIFTDR !== 1'b1) begin
                errors++;
                $display("FAIL core_mirror %0d: got TDO=%b SHIFTDR=%b want %b/1", i, TDO, SHIFTDR, CORE_LOGIC_TDO);
            end
            cyc(0, 1'($urandom));
        end
        rst = 1'b1;
        cyc(0, 1);
        rst = 1'b0;
        m_ir = DEF_IR;
        vectors++;
        if (SHIFTDR !== 1'b0 || TDO !== 1'b0 || IR !== DEF_IR || BSR_UPDATE !== m_upd) begin
            errors++;
            $display("FAIL core_reset: got SHIFTDR=%b TDO=%b IR=%h BSR_UPDATE=%h want 0/0/%h/%h",
                     SHIFTDR, TDO, IR, BSR_UPDATE, DEF_IR, m_upd);
        end
        m_upd = '0;
        cyc(0, 0);
        scan_dr(10, 0, 8'h00);
    endtask

    initial begin
        rst = 1'b1;
        cyc(1, 0); cyc(1, 0);
        rst = 1'b0;
        test_reset();
        test_idcode();
        test_bypass();
        test_sample();
        test_tlr();
        test_core_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
